// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the memory arbiter: data-port op codes, FSM states, grant ids.
package mem_arbiter_pkg;

  localparam logic [7:0] MEM_NOP_OP = 8'h00;
  localparam logic [7:0] MEM_LB_OP  = 8'h01;
  localparam logic [7:0] MEM_LW_OP  = 8'h02;
  localparam logic [7:0] MEM_SB_OP  = 8'h03;
  localparam logic [7:0] MEM_SW_OP  = 8'h04;

  typedef enum logic [1:0] {
    MARB_IDLE   = 2'd0,
    MARB_ACCESS = 2'd1,
    MARB_DONE   = 2'd2
  } marb_state_e;

  typedef enum logic {
    GRANT_IF = 1'b0,
    GRANT_D  = 1'b1
  } grant_e;

  function automatic logic is_store_op(input logic [7:0] op);
    return (op == MEM_SB_OP) || (op == MEM_SW_OP);
  endfunction

endpackage

// File: rtl/mem_lane_ctrl.sv
// Byte-lane handling for the RAM port: byte enables, store-data replication and
// load alignment with sign extension. Purely combinational.
module mem_lane_ctrl
  import mem_arbiter_pkg::*;
(
  input  logic [7:0]  op_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_n_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0] rbyte;

  // Select the addressed byte of the read word (little-endian lanes).
  always_comb begin
    rbyte = rdata_i[7:0];
    case (lane_i)
      2'd1:    rbyte = rdata_i[15:8];
      2'd2:    rbyte = rdata_i[23:16];
      2'd3:    rbyte = rdata_i[31:24];
      default: rbyte = rdata_i[7:0];
    endcase
  end

  // Per-op lane shaping; word ops and reads use all four lanes.
  always_comb begin
    be_n_o  = 4'b0000;
    wdata_o = wdata_i;
    rdata_o = rdata_i;
    case (op_i)
      MEM_SB_OP: begin
        be_n_o  = ~(4'b0001 << lane_i);
        wdata_o = {4{wdata_i[7:0]}};
      end
      MEM_LB_OP: rdata_o = {{24{rbyte[7]}}, rbyte};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter between instruction fetch and data load/store for a single async-SRAM port.
// Each access runs IDLE -> ACCESS (ACCESS_CYCLES cycles) -> DONE; all RAM pins are registered.
// Optional macro MEM_ARB_RR_EN: round-robin on contested cycles instead of data-over-fetch.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ACCESS_CYCLES = 2,
  parameter int unsigned RAM_AW        = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic [7:0]        d_op,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic [31:0]       d_rdata,
  output logic              d_ready,
  output logic              stall_o,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic              ram_wdata_oe,
  input  logic [31:0]       ram_rdata,
  output logic [3:0]        ram_be_n,
  output logic              ram_ce_n,
  output logic              ram_oe_n,
  output logic              ram_we_n
);

  localparam logic [3:0] LastCnt  = 4'(ACCESS_CYCLES - 1);
  // Write strobe is released one cycle before the end to give data hold time.
  localparam logic [3:0] WeOffCnt = 4'(ACCESS_CYCLES - 2);

  marb_state_e       state_q, state_d;
  grant_e            grant_q, grant_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [7:0]        op_q, op_d;
  logic [1:0]        lane_q, lane_d;
  logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
  logic [31:0]       ram_wdata_q, ram_wdata_d;
  logic              ram_wdata_oe_q, ram_wdata_oe_d;
  logic [3:0]        ram_be_n_q, ram_be_n_d;
  logic              ram_ce_n_q, ram_ce_n_d;
  logic              ram_oe_n_q, ram_oe_n_d;
  logic              ram_we_n_q, ram_we_n_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [31:0]       d_rdata_q, d_rdata_d;
  logic              if_ready_q, if_ready_d;
  logic              d_ready_q, d_ready_d;
`ifdef MEM_ARB_RR_EN
  grant_e            last_grant_q, last_grant_d;
`endif

  logic        d_valid;
  logic        pick_data;
  logic [7:0]  sel_op;
  logic [31:0] sel_addr;
  logic [7:0]  lane_op;
  logic [1:0]  lane_sel;
  logic [3:0]  lane_be_n;
  logic [31:0] lane_wdata;
  logic [31:0] lane_rdata;
  logic        unused_addr_hi;

  // Request qualification and arbitration; a fetch is treated as a word load.
  always_comb begin
    d_valid = d_req && (d_op != MEM_NOP_OP);
`ifdef MEM_ARB_RR_EN
    if (d_valid && if_req) begin
      pick_data = (last_grant_q == GRANT_IF);
    end else begin
      pick_data = d_valid;
    end
`else
    pick_data = d_valid;
`endif
    sel_op   = pick_data ? d_op : MEM_LW_OP;
    sel_addr = pick_data ? d_addr : if_addr;
  end

  // Lane logic sees the incoming request while idle and the latched access afterwards.
  assign lane_op  = (state_q == MARB_IDLE) ? sel_op : op_q;
  assign lane_sel = (state_q == MARB_IDLE) ? sel_addr[1:0] : lane_q;

  mem_lane_ctrl u_lane_ctrl (
    .op_i    (lane_op),
    .lane_i  (lane_sel),
    .wdata_i (d_wdata),
    .rdata_i (ram_rdata),
    .be_n_o  (lane_be_n),
    .wdata_o (lane_wdata),
    .rdata_o (lane_rdata)
  );

  assign unused_addr_hi = ^sel_addr[31:RAM_AW+2];

  // Access sequencer: next state, registered RAM pins, read capture and ready pulses.
  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    cnt_d          = cnt_q;
    op_d           = op_q;
    lane_d         = lane_q;
    ram_addr_d     = ram_addr_q;
    ram_wdata_d    = ram_wdata_q;
    ram_wdata_oe_d = ram_wdata_oe_q;
    ram_be_n_d     = ram_be_n_q;
    ram_ce_n_d     = ram_ce_n_q;
    ram_oe_n_d     = ram_oe_n_q;
    ram_we_n_d     = ram_we_n_q;
    if_rdata_d     = if_rdata_q;
    d_rdata_d      = d_rdata_q;
    if_ready_d     = 1'b0;
    d_ready_d      = 1'b0;
`ifdef MEM_ARB_RR_EN
    last_grant_d   = last_grant_q;
`endif
    case (state_q)
      MARB_IDLE: begin
        if (d_valid || if_req) begin
          state_d    = MARB_ACCESS;
          cnt_d      = 4'd0;
          grant_d    = pick_data ? GRANT_D : GRANT_IF;
          op_d       = sel_op;
          lane_d     = sel_addr[1:0];
          ram_addr_d = sel_addr[RAM_AW+1:2];
          ram_ce_n_d = 1'b0;
          ram_be_n_d = lane_be_n;
          if (is_store_op(sel_op)) begin
            ram_we_n_d     = 1'b0;
            ram_oe_n_d     = 1'b1;
            ram_wdata_oe_d = 1'b1;
            ram_wdata_d    = lane_wdata;
          end else begin
            ram_we_n_d     = 1'b1;
            ram_oe_n_d     = 1'b0;
            ram_wdata_oe_d = 1'b0;
          end
`ifdef MEM_ARB_RR_EN
          // Only contested arbitrations move the round-robin pointer.
          if (d_valid && if_req) begin
            last_grant_d = pick_data ? GRANT_D : GRANT_IF;
          end
`endif
        end
      end
      MARB_ACCESS: begin
        if (cnt_q == LastCnt) begin
          state_d        = MARB_DONE;
          ram_ce_n_d     = 1'b1;
          ram_oe_n_d     = 1'b1;
          ram_we_n_d     = 1'b1;
          ram_be_n_d     = 4'b1111;
          ram_wdata_oe_d = 1'b0;
          if (grant_q == GRANT_IF) begin
            if_rdata_d = ram_rdata;
            if_ready_d = 1'b1;
          end else begin
            if (!is_store_op(op_q)) begin
              d_rdata_d = lane_rdata;
            end
            d_ready_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == WeOffCnt) begin
            ram_we_n_d = 1'b1;
          end
        end
      end
      MARB_DONE: begin
        // No grant here: the completing requester needs a cycle to drop its request.
        state_d = MARB_IDLE;
      end
      default: state_d = MARB_IDLE;
    endcase
  end

  // State and output registers; reset parks every strobe inactive.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= MARB_IDLE;
      grant_q        <= GRANT_IF;
      cnt_q          <= 4'd0;
      op_q           <= MEM_NOP_OP;
      lane_q         <= 2'd0;
      ram_addr_q     <= '0;
      ram_wdata_q    <= 32'd0;
      ram_wdata_oe_q <= 1'b0;
      ram_be_n_q     <= 4'b1111;
      ram_ce_n_q     <= 1'b1;
      ram_oe_n_q     <= 1'b1;
      ram_we_n_q     <= 1'b1;
      if_rdata_q     <= 32'd0;
      d_rdata_q      <= 32'd0;
      if_ready_q     <= 1'b0;
      d_ready_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      cnt_q          <= cnt_d;
      op_q           <= op_d;
      lane_q         <= lane_d;
      ram_addr_q     <= ram_addr_d;
      ram_wdata_q    <= ram_wdata_d;
      ram_wdata_oe_q <= ram_wdata_oe_d;
      ram_be_n_q     <= ram_be_n_d;
      ram_ce_n_q     <= ram_ce_n_d;
      ram_oe_n_q     <= ram_oe_n_d;
      ram_we_n_q     <= ram_we_n_d;
      if_rdata_q     <= if_rdata_d;
      d_rdata_q      <= d_rdata_d;
      if_ready_q     <= if_ready_d;
      d_ready_q      <= d_ready_d;
    end
  end

`ifdef MEM_ARB_RR_EN
  // Round-robin pointer; starts at fetch so the first contest goes to data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q <= GRANT_IF;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  assign ram_addr     = ram_addr_q;
  assign ram_wdata    = ram_wdata_q;
  assign ram_wdata_oe = ram_wdata_oe_q;
  assign ram_be_n     = ram_be_n_q;
  assign ram_ce_n     = ram_ce_n_q;
  assign ram_oe_n     = ram_oe_n_q;
  assign ram_we_n     = ram_we_n_q;
  assign if_rdata     = if_rdata_q;
  assign d_rdata      = d_rdata_q;
  assign if_ready     = if_ready_q;
  assign d_ready      = d_ready_q;
  assign stall_o      = (if_req && !if_ready_q) || (d_valid && !d_ready_q);

endmodule
